// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_pkg
// Purpose : Shared definitions for the ALU arbiter. Holds the default
//           operand width, the opcode encoding and the arbiter FSM states.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int DEFAULT_N = 8;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_SHL  = 3'b101,
    OP_SHR  = 3'b110,
    OP_RSVD = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module  : alu_core
// Purpose : Purely combinational ALU. Arithmetic is evaluated one bit wider
//           than the operands so the extra bit gives carry (ADD) or
//           borrow (SUB).
// Ports   : a, b    - operands (N bits)
//           op      - opcode (3 bits, see alu_op_e)
//           result  - low N bits of the operation
//           carry   - carry-out / borrow, 0 for non-arithmetic opcodes
//           err     - reserved opcode was presented
// Revision: 1.0 - initial release
// ============================================================================
module alu_core
  import alu_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   op,
  output logic [N-1:0] result,
  output logic         carry,
  output logic         err
);

  logic [N:0] wide;

  always_comb begin
    wide   = '0;
    result = '0;
    carry  = 1'b0;
    err    = 1'b0;
    case (op)
      OP_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[N-1:0];
        carry  = wide[N];
      end
      OP_SUB: begin
        // Bit N of the wide difference is set exactly when a < b.
        wide   = {1'b0, a} - {1'b0, b};
        result = wide[N-1:0];
        carry  = wide[N];
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SHL:  result = {a[N-2:0], 1'b0};
      OP_SHR:  result = {1'b0, a[N-1:1]};
      default: err    = 1'b1;
    endcase
  end

endmodule : alu_core
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : alu_arbiter
// Purpose : Two-requester round-robin front end for a shared ALU. One
//           operation is accepted in IDLE, executed in EXEC and presented
//           in RESP until the consumer takes it (3-cycle turnaround).
// Ports   : clk, rst_n                - clock, async active-low reset
//           reqX_valid / reqX_ready   - requester X handshake (X = 0, 1)
//           reqX_a, reqX_b, reqX_op   - requester X operands and opcode
//           rsp_valid / rsp_ready     - response handshake
//           rsp_id                    - requester that issued the operation
//           rsp_result, rsp_carry,
//           rsp_err                   - registered ALU outputs
// Revision: 1.0 - initial release
// ============================================================================
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [2:0]   req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [2:0]   req1_op,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_result,
  output logic         rsp_carry,
  output logic         rsp_err
);

  state_e      state, next_state;
  logic        last_grant;
  logic        grant_valid;
  logic        grant_id;
  logic [N-1:0] lat_a, lat_b;
  logic [2:0]  lat_op;
  logic        lat_id;
  logic [N-1:0] core_result;
  logic        core_carry, core_err;

  // On contention the requester not granted last time wins; a lone
  // requester always wins.
  always_comb begin
    grant_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) grant_id = ~last_grant;
    else                          grant_id = req1_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_valid) begin
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          next_state = ST_EXEC;
        end
      end
      ST_EXEC: next_state = ST_RESP;
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      lat_a      <= '0;
      lat_b      <= '0;
      lat_op     <= '0;
      lat_id     <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      if (state == ST_IDLE && grant_valid) begin
        last_grant <= grant_id;
        lat_id     <= grant_id;
        lat_a      <= grant_id ? req1_a  : req0_a;
        lat_b      <= grant_id ? req1_b  : req0_b;
        lat_op     <= grant_id ? req1_op : req0_op;
      end
      if (state == ST_EXEC) begin
        rsp_id     <= lat_id;
        rsp_result <= core_result;
        rsp_carry  <= core_carry;
        rsp_err    <= core_err;
      end
    end
  end

  alu_core #(.N(N)) u_core (
    .a      (lat_a),
    .b      (lat_b),
    .op     (lat_op),
    .result (core_result),
    .carry  (core_carry),
    .err    (core_err)
  );

endmodule : alu_arbiter
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_arbiter
// Purpose : Self-checking bench for alu_arbiter: a table of single-requester
//           operations with hand-computed results, plus directed sequences
//           for arbitration, back-pressure and mid-operation reset.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req0_ready;
  logic [7:0] req0_a, req0_b;
  logic [2:0] req0_op;
  logic       req1_valid, req1_ready;
  logic [7:0] req1_a, req1_b;
  logic [2:0] req1_op;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [7:0] rsp_result;
  logic       rsp_carry, rsp_err;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  alu_arbiter #(.N(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       id;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       c;
    logic       e;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic id, input logic v, input logic [2:0] op,
                         input logic [7:0] a, input logic [7:0] b);
    if (id) begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end
  endtask

  // Waits (bounded) for rsp_valid, checks the fields, then lets the
  // handshake edge pass. Returns the cycle number of the response.
  task automatic collect(input logic exp_id, input logic [7:0] exp_res,
                         input logic exp_c, input logic exp_e,
                         input string name, output int at_cyc);
    bit got = 0;
    at_cyc = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid) begin got = 1; break; end
    end
    if (!got) begin
      check({name, "_rsp_timeout"}, 0, 1);
    end else begin
      at_cyc = cyc;
      check({name, "_id"},     rsp_id,     exp_id);
      check({name, "_result"}, rsp_result, exp_res);
      check({name, "_carry"},  rsp_carry,  exp_c);
      check({name, "_err"},    rsp_err,    exp_e);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_txn(input vec_t v, input string name);
    bit got = 0;
    int ta, tr;
    set_req(v.id, 1'b1, v.op, v.a, v.b);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin got = 1; break; end
    end
    if (!got) begin
      check({name, "_ready_timeout"}, 0, 1);
      set_req(v.id, 1'b0, 3'b000, 8'h00, 8'h00);
      return;
    end
    check({name, "_ready"}, {req1_ready, req0_ready}, v.id ? 2'b10 : 2'b01);
    ta = cyc;
    @(posedge clk); #1;
    // Operand changes after acceptance must not affect the result.
    set_req(v.id, 1'b0, ~v.op, ~v.a, ~v.b);
    collect(v.id, v.res, v.c, v.e, name, tr);
    if (tr >= 0) check({name, "_latency"}, tr - ta, 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int t0, t1, t2, t3;

    //            id   op      a      b      res    c     e
    vecs[0]  = '{1'b0, 3'b000, 8'hF6, 8'h0A, 8'h00, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 3'b000, 8'h21, 8'h37, 8'h58, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 3'b000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 3'b001, 8'h02, 8'h01, 8'h01, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 3'b001, 8'h01, 8'h02, 8'hFF, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 3'b001, 8'h55, 8'h55, 8'h00, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 3'b010, 8'h0F, 8'h22, 8'h02, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 3'b011, 8'hA0, 8'h05, 8'hA5, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 3'b100, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 3'b101, 8'h81, 8'h00, 8'h02, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 3'b101, 8'h7F, 8'h33, 8'hFE, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 3'b110, 8'h81, 8'h00, 8'h40, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 3'b110, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 3'b111, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1};

    rst_n = 1'b1;
    set_req(1'b0, 1'b0, 3'b000, 8'h00, 8'h00);
    set_req(1'b1, 1'b0, 3'b000, 8'h00, 8'h00);
    rsp_ready = 1'b1;

    // Reset takes effect before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("rst_rsp_valid",  rsp_valid,  0);
    check("rst_req_ready",  {req1_ready, req0_ready}, 0);
    check("rst_rsp_fields", {rsp_id, rsp_result, rsp_carry, rsp_err}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Simultaneous requests right after reset: requester 0 wins first.
    set_req(1'b0, 1'b1, 3'b010, 8'h0F, 8'h22);
    set_req(1'b1, 1'b1, 3'b001, 8'h02, 8'h01);
    @(negedge clk);
    check("rr_first_ready", {req1_ready, req0_ready}, 2'b01);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 3'b000, 8'hEE, 8'hEE);
    collect(1'b0, 8'h02, 1'b0, 1'b0, "rr_first", t0);
    @(negedge clk);
    check("rr_second_ready", {req1_ready, req0_ready}, 2'b10);
    @(posedge clk); #1;
    set_req(1'b1, 1'b0, 3'b000, 8'h00, 8'h00);
    collect(1'b1, 8'h01, 1'b0, 1'b0, "rr_second", t0);

    // Both held valid: ids alternate, one operation every 3 cycles.
    set_req(1'b0, 1'b1, 3'b000, 8'h01, 8'h01);
    set_req(1'b1, 1'b1, 3'b100, 8'h0F, 8'hFF);
    collect(1'b0, 8'h02, 1'b0, 1'b0, "alt0", t0);
    collect(1'b1, 8'hF0, 1'b0, 1'b0, "alt1", t1);
    collect(1'b0, 8'h02, 1'b0, 1'b0, "alt2", t2);
    collect(1'b1, 8'hF0, 1'b0, 1'b0, "alt3", t3);
    set_req(1'b0, 1'b0, 3'b000, 8'h00, 8'h00);
    set_req(1'b1, 1'b0, 3'b000, 8'h00, 8'h00);
    check("alt_gap1", t1 - t0, 3);
    check("alt_gap2", t2 - t1, 3);
    check("alt_gap3", t3 - t2, 3);

    for (int i = 0; i < 14; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Back-pressure: response held for 3 cycles with rsp_ready low while
    // requester 0 waits; no ready may be asserted during that time.
    rsp_ready = 1'b0;
    set_req(1'b1, 1'b1, 3'b000, 8'h21, 8'h37);
    @(negedge clk);
    check("bp_accept", {req1_ready, req0_ready}, 2'b10);
    @(posedge clk); #1;
    set_req(1'b1, 1'b0, 3'b000, 8'h00, 8'h00);
    set_req(1'b0, 1'b1, 3'b011, 8'hA0, 8'h05);
    @(negedge clk);
    check("bp_exec_state", {rsp_valid, req1_ready, req0_ready}, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d", i),
            {rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_err, req1_ready, req0_ready},
            {1'b1, 1'b1, 8'h58, 1'b0, 1'b0, 1'b0, 1'b0});
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_still_valid", rsp_valid, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_single_rsp", {rsp_valid, req0_ready}, 2'b01);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 3'b000, 8'h00, 8'h00);
    collect(1'b0, 8'hA5, 1'b0, 1'b0, "bp_next", t0);

    // Reset while the operation is in EXEC: it must vanish.
    set_req(1'b0, 1'b1, 3'b000, 8'h01, 8'h02);
    @(negedge clk);
    check("rstx_accept", req0_ready, 1);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 3'b000, 8'h00, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    check("rstx_async",
          {rsp_valid, req1_ready, req0_ready, rsp_id, rsp_result, rsp_carry, rsp_err}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("rstx_no_stale%0d", i), rsp_valid, 0);
    end
    @(posedge clk); #1;
    run_txn('{1'b1, 3'b001, 8'h01, 8'h02, 8'hFF, 1'b1, 1'b0}, "rstx_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_alu_arbiter
`default_nettype wire
